// File: rtl/fp_vecgen_pkg.sv
// rtl/fp_vecgen_pkg.sv - shared types, LFSR polynomials and operand class shaping
package fp_vecgen_pkg;

  typedef enum logic [2:0] {
    RAW  = 3'd0,
    ZERO = 3'd4,
    INF  = 3'd5,
    QNAN = 3'd6,
    SUB  = 3'd7
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vg_state_e;

  localparam logic [31:0] LFSR32_POLY = 32'h8020_0003;
  localparam logic [15:0] LFSR16_POLY = 16'hB400;

  // Codes 0..3 all mean RAW, so anything not listed passes the raw bits through.
  function automatic logic [31:0] shape_operand(input logic [31:0] raw, input logic [2:0] cls,
                                                input int expW, input int sigW);
    logic [31:0] sigMask;
    logic [31:0] expMask;
    logic [31:0] signBit;
    logic [31:0] sig;
    logic [31:0] sgn;
    logic [31:0] res;
    sigMask = (32'h1 << sigW) - 32'h1;
    expMask = ((32'h1 << expW) - 32'h1) << sigW;
    signBit = 32'h1 << (expW + sigW);
    sig     = raw & sigMask;
    sgn     = raw & signBit;
    case (cls)
      ZERO:    res = sgn;
      INF:     res = sgn | expMask;
      QNAN:    res = sgn | expMask | sig | (32'h1 << (sigW - 1));
      SUB:     res = sgn | ((sig == 32'h0) ? 32'h1 : sig);
      default: res = raw & (signBit | expMask | sigMask);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fma_vec_gen_if.sv
// rtl/fma_vec_gen_if.sv - valid/ready operand vector channel
interface fma_vec_gen_if #(
  parameter int OP_W = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic [OP_W-1:0] c;
  logic [2:0]      rnd;

  modport master (output out_valid, a, b, c, rnd, input out_ready);
  modport slave  (input out_valid, a, b, c, rnd, output out_ready);
endinterface

// File: rtl/fp_lfsr.sv
// rtl/fp_lfsr.sv - right-shifting Galois LFSR, advances only when step is high
module fp_lfsr #(
  parameter int           W    = 32,
  parameter logic [W-1:0] POLY = '1,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (step) begin
      q <= q[0] ? ((q >> 1) ^ POLY) : (q >> 1);
    end
  end

endmodule

// File: rtl/fma_vec_gen.sv
// rtl/fma_vec_gen.sv - seeded {a,b,c,rnd} vector source for the FMA checker
// LFSRs run one vector ahead: each load registers f(q) and advances q in the same edge.
module fma_vec_gen
  import fp_vecgen_pkg::*;
#(
  parameter int          EXP_W   = 8,
  parameter int          SIG_W   = 23,
  parameter logic [31:0] SEED    = 32'hACE1_2345,
  parameter int          NUM_VEC = 1024,
  parameter int          CNT_W   = $clog2(NUM_VEC + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  fma_vec_gen_if.master        vecIf,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic                 done
);

  localparam int          OP_W     = EXP_W + SIG_W + 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] SEED_B   = {SEED_EFF[20:0], SEED_EFF[31:21]};
  localparam logic [31:0] SEED_C   = {SEED_EFF[9:0], SEED_EFF[31:10]};
  localparam logic [15:0] SEED_K   = SEED_EFF[15:0] | 16'h1;

  vg_state_e state, stateNext;

  logic [31:0] qa, qb, qc;
  logic [15:0] qk;
  logic        lfsrStep;

  logic [31:0] shapedA, shapedB, shapedC;
  logic [2:0]  kRnd, nextRnd;

  logic [OP_W-1:0] aReg, bReg, cReg;
  logic [2:0]      rndReg;
  logic            validReg;
  logic            doneReg;
  logic [CNT_W-1:0] cntReg;

  logic accept, lastAccept;
  logic loadVec, incCnt, clrCnt, setValid, clrValid, setDone, clrDone;

  fp_lfsr #(.W(32), .POLY(LFSR32_POLY), .SEED(SEED_EFF)) uLa (
    .clk(clk), .reset(reset), .step(lfsrStep), .q(qa));
  fp_lfsr #(.W(32), .POLY(LFSR32_POLY), .SEED(SEED_B)) uLb (
    .clk(clk), .reset(reset), .step(lfsrStep), .q(qb));
  fp_lfsr #(.W(32), .POLY(LFSR32_POLY), .SEED(SEED_C)) uLc (
    .clk(clk), .reset(reset), .step(lfsrStep), .q(qc));
  fp_lfsr #(.W(16), .POLY(LFSR16_POLY), .SEED(SEED_K)) uLk (
    .clk(clk), .reset(reset), .step(lfsrStep), .q(qk));

  always_comb begin
    shapedA = shape_operand(qa, qk[2:0], EXP_W, SIG_W);
    shapedB = shape_operand(qb, qk[5:3], EXP_W, SIG_W);
    shapedC = shape_operand(qc, qk[8:6], EXP_W, SIG_W);
    kRnd    = qk[11:9];
    nextRnd = (kRnd < 3'd5) ? kRnd : (kRnd - 3'd5);
  end

  assign accept     = validReg && vecIf.out_ready;
  assign lastAccept = accept && (cntReg == CNT_W'(NUM_VEC - 1));
  assign lfsrStep   = loadVec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)      stateNext = RUN;
      RUN:     if (lastAccept) stateNext = DONE;
      DONE:    if (start)      stateNext = RUN;
      default:                 stateNext = IDLE;
    endcase
  end

  always_comb begin
    loadVec  = 1'b0;
    incCnt   = 1'b0;
    clrCnt   = 1'b0;
    setValid = 1'b0;
    clrValid = 1'b0;
    setDone  = 1'b0;
    clrDone  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          loadVec  = 1'b1;
          setValid = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          incCnt = 1'b1;
          if (lastAccept) begin
            clrValid = 1'b1;
            setDone  = 1'b1;
          end else begin
            loadVec = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          clrCnt   = 1'b1;
          clrDone  = 1'b1;
          loadVec  = 1'b1;
          setValid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aReg     <= '0;
      bReg     <= '0;
      cReg     <= '0;
      rndReg   <= '0;
      validReg <= 1'b0;
      doneReg  <= 1'b0;
      cntReg   <= '0;
    end else begin
      if (loadVec) begin
        aReg   <= shapedA[OP_W-1:0];
        bReg   <= shapedB[OP_W-1:0];
        cReg   <= shapedC[OP_W-1:0];
        rndReg <= nextRnd;
      end
      if (setValid)      validReg <= 1'b1;
      else if (clrValid) validReg <= 1'b0;
      if (setDone)       doneReg <= 1'b1;
      else if (clrDone)  doneReg <= 1'b0;
      if (clrCnt)        cntReg <= '0;
      else if (incCnt)   cntReg <= cntReg + CNT_W'(1);
    end
  end

  assign vecIf.out_valid = validReg;
  assign vecIf.a         = aReg;
  assign vecIf.b         = bReg;
  assign vecIf.c         = cReg;
  assign vecIf.rnd       = rndReg;
  assign vec_cnt         = cntReg;
  assign done            = doneReg;

endmodule
